// File: rtl/fitness_kernel_hls_dbg_pkg.sv
// Shared types and helpers for the kernel stream debug probes.
package fitness_kernel_hls_dbg_pkg;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_STALLING = 2'd1,
        ST_BLOCKED  = 2'd2
    } stall_state_e;

    // Index width for NUM_CH channels, never below one bit.
    function automatic int idx_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/fitness_kernel_hls_axis_stall_chan.sv
// One stream channel: stall FSM and saturating consecutive-stall counter.
module fitness_kernel_hls_axis_stall_chan
    import fitness_kernel_hls_dbg_pkg::*;
#(
    parameter int STALL_THRESH = 1024,
    parameter bit IS_READER    = 1'b0,
    parameter int CNT_W        = $clog2(STALL_THRESH + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic tvalid,
    input  logic tready,
    input  logic kill,
    output logic blocked,
    output logic enter_blk
);

    stall_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;
    logic             xfer;

    assign stall = IS_READER ? (tready & ~tvalid) : (tvalid & ~tready);
    assign xfer  = tvalid & tready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill) begin
            state_d = ST_OK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OK: begin
                    if (stall) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (STALL_THRESH == 1) ? ST_BLOCKED : ST_STALLING;
                    end
                end
                ST_STALLING: begin
                    if (stall) begin
                        // cnt_q < STALL_THRESH here, so the increment cannot wrap
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(STALL_THRESH)) state_d = ST_BLOCKED;
                    end else begin
                        state_d = ST_OK;
                        cnt_d   = '0;
                    end
                end
                ST_BLOCKED: begin
                    if (!stall || xfer) begin
                        state_d = ST_OK;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_OK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign blocked   = (state_q == ST_BLOCKED);
    assign enter_blk = (state_d == ST_BLOCKED) && (state_q != ST_BLOCKED);

endmodule

// File: rtl/fitness_kernel_hls_axis_stall_probe.sv
// Per-channel AXI-Stream stall detector feeding the kernel deadlock monitor,
// with a sticky capture of the first channel to block.
module fitness_kernel_hls_axis_stall_probe
    import fitness_kernel_hls_dbg_pkg::*;
#(
    parameter int                NUM_CH       = 2,
    parameter int                STALL_THRESH = 1024,
    parameter logic [NUM_CH-1:0] READ_MASK    = 2'b01,
    parameter int                CNT_W        = $clog2(STALL_THRESH + 1),
    parameter int                IDX_W        = idx_width(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] tvalid,
    input  logic [NUM_CH-1:0] tready,
    input  logic              inst_idle,
    input  logic              clear,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              first_blk_vld,
    output logic [IDX_W-1:0]  first_blk_idx
);

    logic [NUM_CH-1:0] enter_blk;
    logic              kill;
    logic              first_vld_q, first_vld_d;
    logic [IDX_W-1:0]  first_idx_q, first_idx_d;
    logic [IDX_W-1:0]  enc_idx;

    assign kill = clear | inst_idle;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fitness_kernel_hls_axis_stall_chan #(
            .STALL_THRESH (STALL_THRESH),
            .IS_READER    (READ_MASK[i]),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .tvalid    (tvalid[i]),
            .tready    (tready[i]),
            .kill      (kill),
            .blocked   (axis_block_sigs[i]),
            .enter_blk (enter_blk[i])
        );
    end

    // Lowest index wins when several channels block on the same edge.
    always_comb begin
        enc_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (enter_blk[i]) enc_idx = IDX_W'(i);
        end
    end

    always_comb begin
        first_vld_d = first_vld_q;
        first_idx_d = first_idx_q;
        if (clear) begin
            first_vld_d = 1'b0;
            first_idx_d = '0;
        end else if (!first_vld_q && |enter_blk) begin
            first_vld_d = 1'b1;
            first_idx_d = enc_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
        end else begin
            first_vld_q <= first_vld_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign first_blk_vld = first_vld_q;
    assign first_blk_idx = first_idx_q;

endmodule

// File: tb/tb_fitness_kernel_hls_axis_stall_probe.sv
// Directed bench for the stall probe at NUM_CH=2, STALL_THRESH=4, READ_MASK=2'b01.
module tb_fitness_kernel_hls_axis_stall_probe;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] tvalid, tready;
    logic       inst_idle, clear;
    logic [1:0] axis_block_sigs;
    logic       first_blk_vld;
    logic [0:0] first_blk_idx;

    int total = 0;
    int bad   = 0;

    fitness_kernel_hls_axis_stall_probe #(
        .NUM_CH       (2),
        .STALL_THRESH (4),
        .READ_MASK    (2'b01)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .tvalid          (tvalid),
        .tready          (tready),
        .inst_idle       (inst_idle),
        .clear           (clear),
        .axis_block_sigs (axis_block_sigs),
        .first_blk_vld   (first_blk_vld),
        .first_blk_idx   (first_blk_idx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; return 1ns later so outputs are stable and inputs can change.
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] f, input logic v, input logic ix);
        chk({tag, ".flags"}, 32'(axis_block_sigs), 32'(f));
        chk({tag, ".vld"},   32'(first_blk_vld),   32'(v));
        chk({tag, ".idx"},   32'(first_blk_idx),   32'(ix));
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tvalid = '0; tready = '0; inst_idle = 1'b0; clear = 1'b0;
        cyc(2);
        chk_out("reset", 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(1);
        chk_out("idle", 2'b00, 1'b0, 1'b0);

        // Ch1 writer stall blocks after 4 cycles; one transfer releases it.
        tvalid = 2'b10; tready = 2'b00;
        cyc(3);
        chk_out("wr.c3", 2'b00, 1'b0, 1'b0);
        cyc(1);
        chk_out("wr.c4", 2'b10, 1'b1, 1'b1);
        cyc(10);
        chk_out("wr.hold", 2'b10, 1'b1, 1'b1);
        tready = 2'b10;
        cyc(1);
        chk_out("wr.xfer", 2'b00, 1'b1, 1'b1);
        tvalid = 2'b00; tready = 2'b00;

        // Ch0 reader: 3 stalls, a transfer, 3 stalls -> never blocks.
        pulse_clear();
        chk_out("clr1", 2'b00, 1'b0, 1'b0);
        tready = 2'b01; tvalid = 2'b00;
        cyc(3);
        chk("rd.pre", 32'(axis_block_sigs), 32'h0);
        tvalid = 2'b01;
        cyc(1);
        tvalid = 2'b00;
        cyc(3);
        chk_out("rd.post", 2'b00, 1'b0, 1'b0);
        tready = 2'b00;
        cyc(1);

        // Both channels stall together; lowest index captured.
        tready = 2'b01; tvalid = 2'b10;
        cyc(3);
        chk_out("both.c3", 2'b00, 1'b0, 1'b0);
        cyc(1);
        chk_out("both.c4", 2'b11, 1'b1, 1'b0);
        tready = 2'b00; tvalid = 2'b00;
        cyc(1);
        chk("both.rel", 32'(axis_block_sigs), 32'h0);

        // inst_idle drops the flag but not the capture; stall re-blocks later.
        pulse_clear();
        tvalid = 2'b10; tready = 2'b00;
        cyc(4);
        chk_out("idl.blk", 2'b10, 1'b1, 1'b1);
        inst_idle = 1'b1;
        cyc(1);
        inst_idle = 1'b0;
        chk_out("idl.drop", 2'b00, 1'b1, 1'b1);
        cyc(3);
        chk("idl.c3", 32'(axis_block_sigs), 32'h0);
        cyc(1);
        chk_out("idl.reblk", 2'b10, 1'b1, 1'b1);
        tvalid = 2'b00;
        cyc(1);

        // Clear while ch0 blocked with stall persisting.
        pulse_clear();
        tready = 2'b01; tvalid = 2'b00;
        cyc(4);
        chk_out("clr.blk", 2'b01, 1'b1, 1'b0);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk_out("clr.drop", 2'b00, 1'b0, 1'b0);
        cyc(3);
        chk("clr.c3", 32'(axis_block_sigs), 32'h0);
        cyc(1);
        chk_out("clr.reblk", 2'b01, 1'b1, 1'b0);

        // Reset in stall cycle 3 discards the count.
        pulse_clear();
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk_out("rst.mid", 2'b00, 1'b0, 1'b0);
        cyc(3);
        chk_out("rst.c3", 2'b00, 1'b0, 1'b0);
        cyc(1);
        chk_out("rst.c4", 2'b01, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fitness_kernel_hls_axis_stall_probe.md
# fitness_kernel_hls_axis_stall_probe

Per-channel AXI-Stream stall detector that produces the `axis_block_sigs` vector consumed by the kernel deadlock monitor. It watches the tvalid/tready pair of each kernel stream port, counts consecutive stall cycles, and flags a channel as blocked once the stall persists past a threshold. It also latches the first channel to block for debug readback. It sits beside the kernel instance, between the stream ports and the deadlock monitor.

## Interface
- `NUM_CH`, 2, number of monitored stream channels (1..32)
- `STALL_THRESH`, 1024, consecutive stall cycles before a channel is declared blocked (>=1)
- `READ_MASK`, 2'b01, bit i = 1: channel i is a kernel input (reader side); 0: kernel output (writer side)
- `CNT_W`, $clog2(STALL_THRESH+1), stall counter width (derived, not overridden)

Ports:
- `clock`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `tvalid`  in  NUM_CH  per-channel stream valid
- `tready`  in  NUM_CH  per-channel stream ready
- `inst_idle`  in  1  kernel instance idle; suppresses all detection
- `clear`  in  1  one-cycle pulse; drops all blocked flags and the first-block capture
- `axis_block_sigs`  out  NUM_CH  per-channel blocked flag, registered
- `first_blk_vld`  out  1  a first-block capture is held
- `first_blk_idx`  out  $clog2(NUM_CH) (min 1)  index of the first channel to block

## Operation
- Stall condition per channel i:
  - reader (`READ_MASK[i]=1`): `tready & ~tvalid`
  - writer: `tvalid & ~tready`
- Transfer condition: `tvalid & tready`.
- Per-channel FSM, 3 states:
  - OK: counter=0. Stall -> STALLING with counter=1 (or directly BLOCKED if STALL_THRESH==1).
  - STALLING: stall -> counter+1; counter reaching STALL_THRESH -> BLOCKED. Non-stall (transfer or both low) -> OK, counter=0.
  - BLOCKED: flag=1, counter held. Transfer -> OK. Non-stall without transfer (e.g. writer drops tvalid) also -> OK. Stall persists -> remain.
- Precedence, highest first: reset, clear, `inst_idle`, FSM. `clear` or `inst_idle` forces every channel to OK with counter 0 in the same edge.
- Counter never exceeds STALL_THRESH; no wrap.
- First-block capture: on the first edge where any channel enters BLOCKED while `first_blk_vld=0`, set `first_blk_vld=1` and latch that index. If several enter together, the lowest index wins. The capture is held until reset or clear and is unaffected by `inst_idle` or channel recovery.

## Timing
- Reset values: `axis_block_sigs=0`, `first_blk_vld=0`, `first_blk_idx=0`, all FSMs OK, counters 0.
- A stall starting at cycle 0 and held continuously asserts `axis_block_sigs[i]` at the edge ending cycle STALL_THRESH-1. The flag is visible in cycle STALL_THRESH.
- Deassertion: the flag is low in the cycle after the transfer or non-stall cycle.
- `first_blk_vld` and `first_blk_idx` update on the same edge as the corresponding flag.
- `clear` takes effect on the next edge. A stall present during the clear cycle is not counted; counting restarts the following cycle.
- Reset mid-stall discards all counts. There is no combinational path from inputs to outputs.

## Structure
- Shared package `fitness_kernel_hls_dbg_pkg`: FSM state enum (OK, STALLING, BLOCKED) and a helper that computes index width from NUM_CH.
- Natural sub-module `fitness_kernel_hls_axis_stall_chan`: one FSM plus counter. It has parameters STALL_THRESH and IS_READER, and is generated NUM_CH times. The top level holds the priority encoder and the first-block capture.

## Test plan
Defaults for all scenarios: NUM_CH=2, STALL_THRESH=4, READ_MASK=2'b01.
- Ch1 writer: tvalid=1, tready=0 for 4 cycles -> `axis_block_sigs=2'b10` from cycle 4; `first_blk_vld=1`, `first_blk_idx=1`. Then tready=1 for one cycle -> flag 0 the next cycle; capture stays.
- Ch0 reader: tready=1, tvalid=0 for 3 cycles, 1 transfer, then 3 more stall cycles -> never blocks.
- Both channels stall, starting on the same cycle -> both flags rise in cycle 4; `first_blk_idx=0`.
- Ch1 blocked, then `inst_idle=1` for one cycle -> flags 0 the next cycle; capture remains `vld=1`, `idx=1`. Stall continues after idle drops -> re-blocks 4 cycles later.
- `clear` pulse while ch0 is blocked and stall persists -> flag and capture drop. Ch0 re-blocks 4 cycles after the clear cycle; new capture `idx=0`.
- `reset` asserted in stall cycle 3 -> all outputs 0. Stall held after reset release -> blocks 4 cycles after release, not earlier.
